// File: rtl/mmio_responder_if.sv
// -----------------------------------------------------------------------------
// mmio_responder_if
// Processor data-memory side of the MMIO responder. The processor (master)
// presents a word address, store data and store enable every cycle; the
// responder (slave) returns registered read data one cycle later together
// with a select that tells the core to use q_mmio instead of q_dmem.
//   address_dmem [11:0]  word address        (master -> slave)
//   data         [31:0]  store data          (master -> slave)
//   wren                 store enable        (master -> slave)
//   q_mmio       [31:0]  registered read data (slave -> master)
//   mmio_sel             q_mmio valid for previous cycle's address
// -----------------------------------------------------------------------------
interface mmio_responder_if;
   logic [11:0] address_dmem;
   logic [31:0] data;
   logic        wren;
   logic [31:0] q_mmio;
   logic        mmio_sel;

   modport slave  (input  address_dmem, data, wren, output q_mmio, mmio_sel);
   modport master (output address_dmem, data, wren, input  q_mmio, mmio_sel);
endinterface

// File: rtl/mmio_responder.sv
// -----------------------------------------------------------------------------
// mmio_responder
// 16-word MMIO window sitting beside a syncram dmem. Provides a byte TX FIFO
// drained by a ready/valid consumer, a sticky overflow flag, and (optionally)
// a free-running 32-bit timer with compare interrupt.
//   Register offsets (address_dmem[3:0]):
//     0x0 TXDATA (W)  0x1 STATUS (R/W1C)  0x2 TIMER  0x3 CMP  0x4 CTRL
//   STATUS = {pending[7], count[6:3], overflow[2], full[1], empty[0]}
// Ports:
//   clock, reset     single clock; asynchronous active-low reset
//   bus (slave)      address_dmem/data/wren in, q_mmio/mmio_sel out
//   tx_valid/tx_data FIFO head; popped when tx_ready is high
//   irq              level interrupt, equals STATUS.pending
// Build option: define MMIO_TIMER_EN to include TIMER/CMP/CTRL and irq.
// Without it those registers read 0, ignore writes, and irq is tied low.
// -----------------------------------------------------------------------------
module mmio_responder #(
   parameter logic [11:0] BASE_ADDR  = 12'hF00,
   parameter int          FIFO_DEPTH = 8
) (
   input  logic                    clock,
   input  logic                    reset,
   mmio_responder_if.slave         bus,
   output logic                    tx_valid,
   output logic [7:0]              tx_data,
   input  logic                    tx_ready,
   output logic                    irq
);
   localparam int         AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [3:0] DEPTH_C = 4'(FIFO_DEPTH);

   // ---------------- decode ----------------
   logic       sel;
   logic [3:0] off;
   logic       wr_hit;
   assign sel    = (bus.address_dmem[11:4] == BASE_ADDR[11:4]);
   assign off    = bus.address_dmem[3:0];
   assign wr_hit = bus.wren & sel;

   // ---------------- TX FIFO ----------------
   logic [7:0]    mem_q [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [3:0]    count_q, count_d;
   logic          overflow_q, overflow_d;
   logic          empty, full, push_req, push, pop;

   assign empty    = (count_q == 4'd0);
   assign full     = (count_q == DEPTH_C);
   assign tx_valid = !empty;
   assign tx_data  = mem_q[rd_ptr_q];
   assign pop      = tx_valid & tx_ready;
   assign push_req = wr_hit & (off == 4'h0);
   // When full, a same-cycle pop frees the slot the write lands in.
   assign push     = push_req & (!full | pop);

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
         2'b10:   count_d = count_q + 4'd1;
         2'b01:   count_d = count_q - 4'd1;
         default: count_d = count_q;
      endcase
      if (wr_hit && off == 4'h1 && bus.data[2]) overflow_d = 1'b0;
      // set is applied last so it wins over a same-cycle clear
      if (push_req && !push) overflow_d = 1'b1;
   end

   // Storage is not reset: count==0 already hides stale bytes.
   always_ff @(posedge clock) begin
      if (push) mem_q[wr_ptr_q] <= bus.data[7:0];
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

   // ---------------- timer / interrupt ----------------
   logic pending;
`ifdef MMIO_TIMER_EN
   logic [31:0] timer_q, timer_d, cmp_q, cmp_d;
   logic        ctrl_q, ctrl_d, pending_q, pending_d;

   always_comb begin
      timer_d   = timer_q + 32'd1;
      cmp_d     = cmp_q;
      ctrl_d    = ctrl_q;
      pending_d = pending_q;
      if (wr_hit && off == 4'h2) timer_d = bus.data;
      if (wr_hit && off == 4'h3) cmp_d   = bus.data;
      if (wr_hit && off == 4'h4) ctrl_d  = bus.data[0];
      if (wr_hit && off == 4'h1 && bus.data[7]) pending_d = 1'b0;
      if (ctrl_q && timer_q == cmp_q) pending_d = 1'b1;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         timer_q   <= '0;
         cmp_q     <= '0;
         ctrl_q    <= 1'b0;
         pending_q <= 1'b0;
      end else begin
         timer_q   <= timer_d;
         cmp_q     <= cmp_d;
         ctrl_q    <= ctrl_d;
         pending_q <= pending_d;
      end
   end
   assign pending = pending_q;
`else
   logic unused_data;
   assign unused_data = ^{bus.data[31:8]};
   assign pending     = 1'b0;
`endif
   assign irq = pending;

   // ---------------- registered read path ----------------
   logic [31:0] rd_val, q_mmio_q;
   logic        mmio_sel_q;

   always_comb begin
      rd_val = '0;
      if (sel) begin
         case (off)
            4'h1:    rd_val = {24'd0, pending, count_q, overflow_q, full, empty};
`ifdef MMIO_TIMER_EN
            4'h2:    rd_val = timer_q;
            4'h3:    rd_val = cmp_q;
            4'h4:    rd_val = {31'd0, ctrl_q};
`endif
            default: rd_val = '0;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         q_mmio_q   <= '0;
         mmio_sel_q <= 1'b0;
      end else begin
         q_mmio_q   <= rd_val;
         mmio_sel_q <= sel;
      end
   end
   assign bus.q_mmio   = q_mmio_q;
   assign bus.mmio_sel = mmio_sel_q;
endmodule

// File: tb/tb_mmio_responder.sv
module tb_mmio_responder;
   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       tx_valid, tx_ready, irq;
   logic [7:0] tx_data;
   int         checks = 0;
   int         errors = 0;

   mmio_responder_if bus ();

   mmio_responder #(.BASE_ADDR(12'hF00), .FIFO_DEPTH(8)) dut (
      .clock    (clock),
      .reset    (reset),
      .bus      (bus.slave),
      .tx_valid (tx_valid),
      .tx_data  (tx_data),
      .tx_ready (tx_ready),
      .irq      (irq)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [11:0] a, input logic [31:0] d);
      bus.address_dmem = a;
      bus.data         = d;
      bus.wren         = 1'b1;
      tick();
      bus.wren         = 1'b0;
      bus.address_dmem = 12'h000;
   endtask

   task automatic rd(input string tag, input logic [11:0] a, input logic sel_exp,
                     input logic [31:0] q_exp);
      bus.address_dmem = a;
      bus.wren         = 1'b0;
      tick();
      chk({tag, ".sel"}, {31'd0, bus.mmio_sel}, {31'd0, sel_exp});
      chk({tag, ".q"}, bus.q_mmio, q_exp);
      bus.address_dmem = 12'h000;
   endtask

   initial begin
      bus.address_dmem = 12'h000;
      bus.data         = '0;
      bus.wren         = 1'b0;
      tx_ready         = 1'b0;

      // reset state
      #1;
      chk("rst.tx_valid", {31'd0, tx_valid}, 32'd0);
      chk("rst.irq", {31'd0, irq}, 32'd0);
      chk("rst.sel", {31'd0, bus.mmio_sel}, 32'd0);
      chk("rst.q", bus.q_mmio, 32'd0);
      #11 reset = 1'b1;
      tick();

      // decode / read latency
      rd("status0", 12'hF01, 1'b1, 32'h1);
      rd("nodec", 12'h100, 1'b0, 32'h0);
      rd("unused_off", 12'hF05, 1'b1, 32'h0);

      // writes outside the window or without wren do not push
      wr(12'h100, 32'h55);
      bus.address_dmem = 12'hF00; bus.data = 32'h66; tick();
      chk("nopush.valid", {31'd0, tx_valid}, 32'd0);

      // three bytes, then drain back to back
      wr(12'hF00, 32'h41);
      chk("first.valid", {31'd0, tx_valid}, 32'd1);
      chk("first.data", {24'd0, tx_data}, 32'h41);
      wr(12'hF00, 32'h42);
      wr(12'hF00, 32'h43);
      rd("status3", 12'hF01, 1'b1, 32'h18);
      tx_ready = 1'b1;
      chk("drain0", {24'd0, tx_data}, 32'h41);
      tick(); chk("drain1", {24'd0, tx_data}, 32'h42);
      tick(); chk("drain2", {24'd0, tx_data}, 32'h43);
      tick(); chk("drain.empty", {31'd0, tx_valid}, 32'd0);
      tx_ready = 1'b0;
      rd("status_empty", 12'hF01, 1'b1, 32'h1);

      // overflow: nine writes into eight slots
      for (int i = 0; i < 9; i++) wr(12'hF00, 32'h10 + i);
      chk("full.head_stable", {24'd0, tx_data}, 32'h10);
      rd("status_ovf", 12'hF01, 1'b1, 32'h46);
      wr(12'hF01, 32'h4);
      rd("status_w1c", 12'hF01, 1'b1, 32'h42);

      // full FIFO: push and pop in the same cycle
      bus.address_dmem = 12'hF00; bus.data = 32'h20; bus.wren = 1'b1; tx_ready = 1'b1;
      tick();
      bus.wren = 1'b0; bus.address_dmem = 12'h000; tx_ready = 1'b0;
      rd("status_pushpop", 12'hF01, 1'b1, 32'h42);
      tx_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("order%0d", i), {24'd0, tx_data}, (i < 7) ? 32'h11 + i : 32'h20);
         tick();
      end
      chk("order.empty", {31'd0, tx_valid}, 32'd0);
      tx_ready = 1'b0;

`ifdef MMIO_TIMER_EN
      wr(12'hF02, 32'hFFFF_FFFE);
      wr(12'hF03, 32'h1);
      wr(12'hF04, 32'h1);
      chk("irq.before0", {31'd0, irq}, 32'd0);
      tick(); chk("irq.before1", {31'd0, irq}, 32'd0);
      tick(); chk("irq.set", {31'd0, irq}, 32'd1);
      rd("status_pend", 12'hF01, 1'b1, 32'h81);
      wr(12'hF01, 32'h80);
      chk("irq.clr", {31'd0, irq}, 32'd0);
      rd("cmp", 12'hF03, 1'b1, 32'h1);
      rd("ctrl", 12'hF04, 1'b1, 32'h1);
      wr(12'hF02, 32'h100);
      rd("timer", 12'hF02, 1'b1, 32'h100);
`else
      wr(12'hF02, 32'h1234);
      wr(12'hF04, 32'h1);
      rd("timer_off", 12'hF02, 1'b1, 32'h0);
      rd("ctrl_off", 12'hF04, 1'b1, 32'h0);
      chk("irq_off", {31'd0, irq}, 32'd0);
`endif

      // asynchronous reset with bytes queued
      wr(12'hF00, 32'hA1);
      wr(12'hF00, 32'hA2);
      wr(12'hF00, 32'hA3);
      rd("status_pre", 12'hF01, 1'b1, 32'h18);
      #3 reset = 1'b0;
      #1;
      chk("async.tx_valid", {31'd0, tx_valid}, 32'd0);
      chk("async.sel", {31'd0, bus.mmio_sel}, 32'd0);
      #2 reset = 1'b1;
      tick();
`ifdef MMIO_TIMER_EN
      rd("timer_restart", 12'hF02, 1'b1, 32'h1);
`endif
      rd("status_post", 12'hF01, 1'b1, 32'h1);
      chk("post.tx_valid", {31'd0, tx_valid}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
